// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Programmable clock divider with 50% duty cycle for both odd
//               and even ratios. Ratio changes take effect only at a period
//               boundary, so a running output period is never cut short or
//               stretched.
// Ports       : i_clk      - source clock (only clock domain)
//               i_rst      - asynchronous active-high reset
//               i_en       - run request; low stops at the next boundary
//               i_load     - single-cycle ratio change request
//               i_ratio    - requested ratio (valid 2..2^W-1)
//               o_clk      - divided clock
//               o_active   - high while the divider is running
//               o_ratio    - ratio currently in effect
//               o_upd_done - pulse in the cycle a new ratio takes effect
//               o_err      - pulse after a rejected load (ratio < 2)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
   parameter int unsigned W         = 8,
   parameter int unsigned RST_RATIO = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic         i_load,
   input  logic [W-1:0] i_ratio,
   output logic         o_clk,
   output logic         o_active,
   output logic [W-1:0] o_ratio,
   output logic         o_upd_done,
   output logic         o_err
);

   localparam logic [W-1:0] C_RST_RATIO = W'(RST_RATIO);
   localparam logic [W-1:0] C_MIN_RATIO = W'(2);
   localparam logic [W-1:0] C_ONE       = W'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         r_state, w_state_nx;
   logic [W-1:0]   r_cnt,   w_cnt_nx;
   logic           r_p,     w_p_nx;
   logic           r_n;
   logic [W-1:0]   r_ratio, w_ratio_nx;
   logic [W-1:0]   r_pend,  w_pend_nx;
   logic           r_pend_v, w_pend_v_nx;
   logic           r_upd,   w_upd_nx;
   logic           r_err,   w_err_nx;

   logic [W-1:0]   w_half;
   logic [W-1:0]   w_last;
   logic [W-1:0]   w_cnt_inc;
   logic           w_apply;

   // All ratio arithmetic stays in W bits: R >= 2 so R-1 never underflows,
   // and the counter never exceeds R-1 so the increment never wraps.
   assign w_half    = r_ratio >> 1;
   assign w_last    = r_ratio - C_ONE;
   assign w_cnt_inc = r_cnt + C_ONE;

   // -------------------------------------------------------------------------
   // State register and all posedge flops
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_p      <= 1'b0;
         r_ratio  <= C_RST_RATIO;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
         r_upd    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_p      <= w_p_nx;
         r_ratio  <= w_ratio_nx;
         r_pend   <= w_pend_nx;
         r_pend_v <= w_pend_v_nx;
         r_upd    <= w_upd_nx;
         r_err    <= w_err_nx;
      end
   end

   // Negedge copy of p supplies the extra half period for odd ratios.
   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_n <= 1'b0;
      end else begin
         r_n <= r_p;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-value logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_p_nx      = r_p;
      w_ratio_nx  = r_ratio;
      w_pend_nx   = r_pend;
      w_pend_v_nx = r_pend_v;
      w_upd_nx    = 1'b0;
      w_err_nx    = 1'b0;
      w_apply     = 1'b0;

      case (r_state)
         IDLE: begin
            w_cnt_nx = '0;
            w_p_nx   = 1'b0;
            w_apply  = r_pend_v;
            if (i_en) begin
               // Output rises on the same edge that starts the run.
               w_state_nx = RUN;
               w_p_nx     = 1'b1;
            end
         end
         RUN: begin
            if (r_cnt == w_last) begin
               // Period boundary: the only place a pending ratio lands.
               w_apply  = r_pend_v;
               w_cnt_nx = '0;
               if (i_en) begin
                  // floor(R/2) >= 1 for any legal ratio, so p is high at cnt 0.
                  w_p_nx = 1'b1;
               end else begin
                  w_state_nx = IDLE;
                  w_p_nx     = 1'b0;
               end
            end else begin
               w_cnt_nx = w_cnt_inc;
               w_p_nx   = (w_cnt_inc < w_half);
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_p_nx     = 1'b0;
         end
      endcase

      if (w_apply) begin
         w_ratio_nx  = r_pend;
         w_pend_v_nx = 1'b0;
         w_upd_nx    = 1'b1;
      end

      // A load in the same cycle as an apply becomes the next pending value.
      if (i_load) begin
         if (i_ratio >= C_MIN_RATIO) begin
            w_pend_nx   = i_ratio;
            w_pend_v_nx = 1'b1;
         end else begin
            w_err_nx = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: o_clk is a single OR of two flops; n is masked for even ratios.
   // The mask only changes at a boundary, where n is always low.
   // -------------------------------------------------------------------------
   assign o_clk      = r_p | (r_n & r_ratio[0]);
   assign o_active   = (r_state == RUN);
   assign o_ratio    = r_ratio;
   assign o_upd_done = r_upd;
   assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Self-checking bench for clk_div_prog. A table of per-cycle
//               vectors covers load, odd/even waveforms, mid-period ratio
//               change and rejected loads; hand sequences cover stop/restart
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

   logic       i_clk;
   logic       i_rst;
   logic       i_en;
   logic       i_load;
   logic [7:0] i_ratio;
   logic       o_clk;
   logic       o_active;
   logic [7:0] o_ratio;
   logic       o_upd_done;
   logic       o_err;

   int checks = 0;
   int errors = 0;

   clk_div_prog #(.W(8), .RST_RATIO(2)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_load     (i_load),
      .i_ratio    (i_ratio),
      .o_clk      (o_clk),
      .o_active   (o_active),
      .o_ratio    (o_ratio),
      .o_upd_done (o_upd_done),
      .o_err      (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Counts o_clk rising edges while a window is open.
   logic mon_en = 1'b0;
   int   rises  = 0;
   always @(posedge o_clk) if (mon_en) rises++;

   typedef struct {
      logic       en;
      logic       ld;
      logic [7:0] r;
      logic       cp;   // o_clk just after posedge
      logic       cn;   // o_clk just after negedge
      logic       act;
      logic [7:0] rat;
      logic       upd;
      logic       err;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic en, ld, input logic [7:0] r,
                      input logic cp, cn, act, input logic [7:0] rat,
                      input logic upd, err);
      vec_t v;
      v.en = en; v.ld = ld; v.r = r; v.cp = cp; v.cn = cn;
      v.act = act; v.rat = rat; v.upd = upd; v.err = err;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Drive inputs for one cycle, then land 1 time unit after the posedge.
   task automatic step(input logic en, ld, input logic [7:0] r);
      i_en = en; i_load = ld; i_ratio = r;
      @(posedge i_clk); #1;
   endtask

   task automatic to_neg();
      @(negedge i_clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_en = 1'b0; i_load = 1'b0; i_ratio = 8'd0;

      //   en ld r    cp cn act rat upd err
      add(0, 1, 4,   0, 0, 0,  2,  0, 0);  // load 4 while idle
      add(1, 0, 0,   1, 1, 1,  4,  1, 0);  // apply + start, rise same edge
      add(1, 0, 0,   1, 1, 1,  4,  0, 0);  // cnt1
      add(1, 0, 0,   0, 0, 1,  4,  0, 0);  // cnt2
      add(1, 0, 0,   0, 0, 1,  4,  0, 0);  // cnt3
      add(1, 0, 0,   1, 1, 1,  4,  0, 0);  // cnt0
      add(1, 0, 0,   1, 1, 1,  4,  0, 0);  // cnt1
      add(1, 1, 7,   0, 0, 1,  4,  0, 0);  // load 7 at cnt1 -> cnt2
      add(1, 0, 0,   0, 0, 1,  4,  0, 0);  // cnt3
      add(1, 0, 0,   1, 1, 1,  7,  1, 0);  // wrap, ratio 7 takes effect
      add(1, 0, 0,   1, 1, 1,  7,  0, 0);  // cnt1
      add(1, 0, 0,   1, 1, 1,  7,  0, 0);  // cnt2
      add(1, 0, 0,   1, 0, 1,  7,  0, 0);  // cnt3: falls on negedge
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt4
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt5
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt6
      add(1, 0, 0,   1, 1, 1,  7,  0, 0);  // cnt0
      add(1, 1, 1,   1, 1, 1,  7,  0, 1);  // reject ratio 1 -> err
      add(1, 0, 0,   1, 1, 1,  7,  0, 0);  // cnt2
      add(1, 0, 0,   1, 0, 1,  7,  0, 0);  // cnt3
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt4
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt5
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt6
      add(1, 0, 0,   1, 1, 1,  7,  0, 0);  // cnt0, no update pulse
      add(1, 1, 5,   1, 1, 1,  7,  0, 0);  // load 5 -> cnt1
      add(1, 0, 0,   1, 1, 1,  7,  0, 0);  // cnt2
      add(1, 0, 0,   1, 0, 1,  7,  0, 0);  // cnt3
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt4
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt5
      add(1, 0, 0,   0, 0, 1,  7,  0, 0);  // cnt6
      add(1, 0, 0,   1, 1, 1,  5,  1, 0);  // ratio 5 takes effect
      add(1, 0, 0,   1, 1, 1,  5,  0, 0);  // cnt1
      add(1, 0, 0,   1, 0, 1,  5,  0, 0);  // cnt2: 2.5 high
      add(1, 0, 0,   0, 0, 1,  5,  0, 0);  // cnt3
      add(1, 0, 0,   0, 0, 1,  5,  0, 0);  // cnt4
      add(1, 0, 0,   1, 1, 1,  5,  0, 0);  // cnt0, period 5

      // Reset state
      #1;
      chk("rst_clk",    32'(o_clk),      32'd0);
      chk("rst_active", 32'(o_active),   32'd0);
      chk("rst_ratio",  32'(o_ratio),    32'd2);
      chk("rst_upd",    32'(o_upd_done), 32'd0);
      chk("rst_err",    32'(o_err),      32'd0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk); #1;
      i_rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].en, vt[i].ld, vt[i].r);
         chk($sformatf("v%0d_clk_pos", i), 32'(o_clk),      32'(vt[i].cp));
         chk($sformatf("v%0d_active",  i), 32'(o_active),   32'(vt[i].act));
         chk($sformatf("v%0d_ratio",   i), 32'(o_ratio),    32'(vt[i].rat));
         chk($sformatf("v%0d_upd",     i), 32'(o_upd_done), 32'(vt[i].upd));
         chk($sformatf("v%0d_err",     i), 32'(o_err),      32'(vt[i].err));
         to_neg();
         chk($sformatf("v%0d_clk_neg", i), 32'(o_clk),      32'(vt[i].cn));
      end

      // Stop/restart at ratio 6. Running at 5, cnt0 now.
      step(1, 1, 6);                                   // cnt1, pend 6
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);     // cnt2..4
      step(1, 0, 0);                                   // boundary
      chk("r6_ratio", 32'(o_ratio),    32'd6);
      chk("r6_upd",   32'(o_upd_done), 32'd1);
      step(1, 0, 0);                                   // cnt1
      to_neg();
      step(0, 0, 0);                                   // en low seen at cnt1 -> cnt2
      chk("stop_c2_clk", 32'(o_clk),    32'd1);
      chk("stop_c2_act", 32'(o_active), 32'd1);
      step(0, 0, 0);                                   // cnt3
      chk("stop_c3_clk", 32'(o_clk),    32'd0);
      step(0, 0, 0); step(0, 0, 0);                    // cnt4, cnt5
      chk("stop_c5_act", 32'(o_active), 32'd1);
      step(0, 0, 0);                                   // boundary -> IDLE
      chk("stop_idle_act", 32'(o_active), 32'd0);
      chk("stop_idle_clk", 32'(o_clk),    32'd0);
      mon_en = 1'b1;
      step(0, 0, 0); to_neg(); step(0, 0, 0); to_neg();
      mon_en = 1'b0;
      chk("stop_held_rises", 32'(rises),  32'd0);
      chk("stop_held_act",   32'(o_active), 32'd0);
      step(1, 0, 0);
      chk("restart_clk", 32'(o_clk),    32'd1);
      chk("restart_act", 32'(o_active), 32'd1);
      chk("restart_rat", 32'(o_ratio),  32'd6);

      // Reset in the high phase at ratio 7.
      step(1, 1, 7);                                   // cnt1, pend 7
      begin : wait_upd
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            step(1, 0, 0);
            if (o_upd_done === 1'b1) seen = 1'b1;
         end
         chk("r7_upd_seen", 32'(seen), 32'd1);
      end
      chk("r7_ratio", 32'(o_ratio), 32'd7);
      step(1, 0, 0);                                   // cnt1, high
      chk("r7_high", 32'(o_clk), 32'd1);
      #2;
      i_rst = 1'b1; i_en = 1'b0;
      #1;
      chk("arst_clk",   32'(o_clk),    32'd0);
      chk("arst_act",   32'(o_active), 32'd0);
      chk("arst_ratio", 32'(o_ratio),  32'd2);
      rises = 0;
      mon_en = 1'b1;
      @(posedge i_clk); #3;
      i_rst = 1'b0;
      repeat (3) begin @(posedge i_clk); #1; end
      to_neg();
      mon_en = 1'b0;
      chk("arst_release_rises", 32'(rises),    32'd0);
      chk("arst_release_act",   32'(o_active), 32'd0);
      step(1, 0, 0);
      chk("arst_start_clk", 32'(o_clk),   32'd1);
      chk("arst_start_rat", 32'(o_ratio), 32'd2);
      step(1, 0, 0);
      chk("arst_r2_low", 32'(o_clk), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
